uart_tx: RTL and testbench

//  - Serial UART transmitter; the peer of the team's 16x-oversampling receiver.
//  - Frame: start(0), DATA_BITS data LSB-first, optional odd parity, stop(1).
//  - Shares the baud-tick generator (tick_16x) with the receiver and drives the line pin.
//  - Sits between a valid/ready byte source (CPU register or FIFO) and the UART TX pad.

---
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional odd parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to add a second stop bit (STOP2) before tx_done.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVS_FACTOR = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 parity_enable,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CntW = $clog2(OVS_FACTOR);
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(OVS_FACTOR - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        StStop   = 3'd4,
        StStop2  = 3'd5
`else
        StStop   = 3'd4
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      os_count_q, os_count_d;
    logic [IdxW-1:0]      bit_index_q, bit_index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_pin_q, tx_pin_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 period_end;

    assign period_end = tick_16x && (os_count_q == CntLast);

    always_comb begin
        state_d     = state_q;
        os_count_d  = os_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        tx_ready_d  = tx_ready_q;
        tx_busy_d   = tx_busy_q;
        tx_done_d   = 1'b0;

        // Ticks only advance the bit counter while a frame is in progress.
        if (state_q != StIdle && tick_16x) begin
            os_count_d = period_end ? '0 : os_count_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                os_count_d = '0;
                if (tx_valid) begin
                    shift_d     = tx_data;
                    par_en_d    = parity_enable;
                    par_bit_d   = ~^tx_data;
                    bit_index_d = '0;
                    state_d     = StStart;
                    tx_ready_d  = 1'b0;
                    tx_busy_d   = 1'b1;
                end
            end
            StStart: begin
                if (period_end) begin
                    state_d     = StData;
                    bit_index_d = '0;
                end
            end
            StData: begin
                if (period_end) begin
                    if (bit_index_q == IdxLast) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_index_d = bit_index_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (period_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (period_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    state_d = StStop2;
`else
                    state_d    = StIdle;
                    tx_done_d  = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_ready_d = 1'b1;
`endif
                end
            end
`ifdef UART_TX_TWO_STOP_EN
            StStop2: begin
                if (period_end) begin
                    state_d    = StIdle;
                    tx_done_d  = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_ready_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = StIdle;
                os_count_d  = '0;
                bit_index_d = '0;
                tx_ready_d  = 1'b1;
                tx_busy_d   = 1'b0;
            end
        endcase

        // The line level is registered from the next state so it changes on the same edge.
        case (state_d)
            StStart:  tx_pin_d = 1'b0;
            StData:   tx_pin_d = shift_d[bit_index_d];
            StParity: tx_pin_d = par_bit_d;
            default:  tx_pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            os_count_q  <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            tx_pin_q    <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_count_q  <= os_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            tx_pin_q    <= tx_pin_d;
            tx_ready_q  <= tx_ready_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_pin   = tx_pin_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames are decoded mid-bit from tx_pin and compared to hand values.
// Honours UART_TX_TWO_STOP_EN by expecting one extra stop bit per frame.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
    localparam int ExtraStop = 1;
`else
    localparam int ExtraStop = 0;
`endif

    logic       clk;
    logic       reset;
    logic       tick_16x;
    logic       parity_enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_pin;
    logic       tx_busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;
    int tick_div = 0;

    uart_tx #(
        .DATA_BITS (8),
        .OVS_FACTOR(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_16x     (tick_16x),
        .parity_enable(parity_enable),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_pin       (tx_pin),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clocks, updated on the falling edge.
    initial begin
        tick_16x = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            tick_16x = (tick_div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] data, input logic par, input bit align,
                          input bit hold, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (align && !tick_16x && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        tx_data       = data;
        parity_enable = par;
        tx_valid      = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".start_pin"}, 32'(tx_pin), 32'd0);
        check({tag, ".start_busy"}, 32'(tx_busy), 32'd1);
        check({tag, ".start_ready"}, 32'(tx_ready), 32'd0);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic monitor(input logic [15:0] exp_frame_base, input int exp_ticks_base,
                           input string tag);
        logic [15:0] frame;
        logic [15:0] exp_frame;
        logic        prev_pin;
        int          ticks;
        int          exp_ticks;
        int          cycles;
        int          glitches;
        int          bad_status;
        bit          done;
        frame      = '0;
        ticks      = 0;
        cycles     = 0;
        glitches   = 0;
        bad_status = 0;
        done       = 1'b0;
        exp_ticks  = exp_ticks_base + 16 * ExtraStop;
        exp_frame  = exp_frame_base;
        if (ExtraStop != 0) exp_frame[exp_ticks_base / 16] = 1'b1;
        prev_pin = tx_pin;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (tick_16x) ticks++;
            if (tx_pin !== prev_pin && !(tick_16x && (ticks % 16) == 0)) glitches++;
            if (tick_16x && (ticks % 16) == 8 && (ticks / 16) < 16) frame[ticks / 16] = tx_pin;
            if (tx_done === 1'b1) done = 1'b1;
            else if (!(tx_busy === 1'b1 && tx_ready === 1'b0)) bad_status++;
            prev_pin = tx_pin;
        end
        check({tag, ".done_seen"}, 32'(done), 32'd1);
        check({tag, ".ticks"}, 32'(ticks), 32'(exp_ticks));
        check({tag, ".frame"}, 32'(frame), 32'(exp_frame));
        check({tag, ".glitches"}, 32'(glitches), 32'd0);
        check({tag, ".busy_ready"}, 32'(bad_status), 32'd0);
        check({tag, ".done_ready"}, 32'(tx_ready), 32'd1);
        check({tag, ".done_busy"}, 32'(tx_busy), 32'd0);
        check({tag, ".done_pin"}, 32'(tx_pin), 32'd1);
    endtask

    task automatic idle_after(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 32'(tx_done), 32'd0);
        check({tag, ".idle_ready"}, 32'(tx_ready), 32'd1);
        check({tag, ".idle_pin"}, 32'(tx_pin), 32'd1);
    endtask

    logic [7:0]  lb_data  [6] = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'hFF, 8'hA5};
    logic        lb_par   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] lb_frame [6] = '{16'h200, 16'h3FE, 16'h74A, 16'h678, 16'h7FE, 16'h34A};
    int          lb_ticks [6] = '{160, 160, 176, 176, 176, 160};

    initial begin
        int t;
        int c;
        reset         = 1'b1;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        parity_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.pin", 32'(tx_pin), 32'd1);
        check("reset.ready", 32'(tx_ready), 32'd1);
        check("reset.busy", 32'(tx_busy), 32'd0);
        check("reset.done", 32'(tx_done), 32'd0);
        reset = 1'b0;

        // Ticks while idle must not move the line.
        repeat (40) @(posedge clk);
        #1;
        check("idle.pin", 32'(tx_pin), 32'd1);
        check("idle.busy", 32'(tx_busy), 32'd0);

        accept(8'h55, 1'b0, 1'b0, 1'b0, "t1");
        monitor(16'h2AA, 160, "t1");
        idle_after("t1");

        accept(8'h00, 1'b1, 1'b0, 1'b0, "t2a");
        monitor(16'h600, 176, "t2a");
        idle_after("t2a");
        accept(8'h07, 1'b1, 1'b1, 1'b0, "t2b");
        monitor(16'h40E, 176, "t2b");
        idle_after("t2b");

        for (int i = 0; i < 6; i++) begin
            accept(lb_data[i], lb_par[i], i[0], 1'b0, $sformatf("t3_%0d", i));
            monitor(lb_frame[i], lb_ticks[i], $sformatf("t3_%0d", i));
            idle_after($sformatf("t3_%0d", i));
        end

        // Back-to-back with tx_valid held; tx_data changes while each frame is on the line.
        accept(8'h12, 1'b0, 1'b0, 1'b1, "t4a");
        tx_data = 8'h34;
        monitor(16'h224, 160, "t4a");
        @(posedge clk);
        #1;
        check("t4.b2b_pin", 32'(tx_pin), 32'd0);
        check("t4.b2b_done", 32'(tx_done), 32'd0);
        check("t4.b2b_busy", 32'(tx_busy), 32'd1);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        monitor(16'h268, 160, "t4b");
        idle_after("t4b");

        // Reset for one edge during data bit 4 of 0xF0.
        accept(8'hF0, 1'b0, 1'b0, 1'b0, "t5a");
        t = 0;
        c = 0;
        while (t < 88 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            if (tick_16x) t++;
        end
        check("t5.reach_bit4", 32'(t), 32'd88);
        check("t5.mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5.rst_pin", 32'(tx_pin), 32'd1);
        check("t5.rst_busy", 32'(tx_busy), 32'd0);
        check("t5.rst_ready", 32'(tx_ready), 32'd1);
        check("t5.rst_done", 32'(tx_done), 32'd0);
        repeat (80) @(posedge clk);
        #1;
        check("t5.abandon_pin", 32'(tx_pin), 32'd1);
        check("t5.abandon_busy", 32'(tx_busy), 32'd0);
        accept(8'h81, 1'b0, 1'b0, 1'b0, "t5b");
        monitor(16'h302, 160, "t5b");
        idle_after("t5b");

        accept(8'hC3, 1'b0, 1'b1, 1'b0, "t6");
        monitor(16'h386, 160, "t6");
        idle_after("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
